spi_ram_ctrl: RTL and testbench



---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_ram_array.sv | 42 ++++
 rtl/spi_ram_ctrl.sv | 122 ++++++++++++
 tb/tb_spi_ram_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_pkg : opcodes, FSM encoding and widths shared with the SPI slave  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package spi_pkg;

    localparam int SPI_DIN_W  = 10;
    localparam int SPI_DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_ram_array.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_ram_array : MEM_DEPTH x DATA_W storage, sync write, registered rd |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module spi_ram_array #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic              w_wr_ok;
    logic              w_rd_ok;

    // Out-of-range addresses only exist when the array is shallower than the address space.
    generate
        if (MEM_DEPTH < 2**ADDR_SIZE) begin : g_partial
            assign w_wr_ok = (waddr < ADDR_SIZE'(MEM_DEPTH));
            assign w_rd_ok = (raddr < ADDR_SIZE'(MEM_DEPTH));
        end else begin : g_full
            assign w_wr_ok = 1'b1;
            assign w_rd_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we && w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= w_rd_ok ? r_mem[raddr] : '0;
    end

endmodule
`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_ram_ctrl : command-decoding RAM behind the SPI slave              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module spi_ram_ctrl
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int DATA_W    = SPI_DATA_W,
    parameter int TX_HOLD   = 8
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [ADDR_SIZE+1:0] din,
    input  logic                 rx_valid,
    output logic [DATA_W-1:0]    dout,
    output logic                 tx_valid
);

    localparam int              HOLD_W    = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(TX_HOLD - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_SIZE-1:0]  r_wr_addr;
    logic [ADDR_SIZE-1:0]  r_rd_addr;
    logic                  r_rx_valid_q;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [HOLD_W-1:0]     w_next_cnt;
    logic [DATA_W-1:0]     w_next_dout;
    logic                  w_next_tx;
    logic                  w_accept;
    logic [1:0]            w_op;
    logic [ADDR_SIZE-1:0]  w_payload;
    logic                  w_rd_cmd;
    logic                  w_wr_cmd;
    logic [DATA_W-1:0]     w_ram_q;

    // A held rx_valid is one command: act only on its rising edge.
    assign w_accept  = rx_valid & ~r_rx_valid_q;
    assign w_op      = din[ADDR_SIZE+1:ADDR_SIZE];
    assign w_payload = din[ADDR_SIZE-1:0];
    assign w_rd_cmd  = w_accept && (w_op == OP_RD_DATA);
    assign w_wr_cmd  = w_accept && (w_op == OP_WR_DATA);

    // The array samples rd_addr every cycle, so its output is ready for the FETCH cycle.
    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_W    (DATA_W)
    ) u_ram (
        .clk   (CLK),
        .we    (w_wr_cmd),
        .waddr (r_wr_addr),
        .wdata (w_payload[DATA_W-1:0]),
        .raddr (r_rd_addr),
        .rdata (w_ram_q)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_dout  = dout;
        w_next_tx    = tx_valid;
        w_next_cnt   = r_hold_cnt;
        case (r_state)
            IDLE: begin
                if (w_rd_cmd) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                w_next_dout  = w_ram_q;
                w_next_tx    = 1'b1;
                w_next_cnt   = HOLD_LOAD;
                w_next_state = w_rd_cmd ? FETCH : SEND;
            end
            SEND: begin
                // A restart keeps tx_valid high straight through the refetch.
                if (w_rd_cmd) begin
                    w_next_state = FETCH;
                end else if (r_hold_cnt == '0) begin
                    w_next_tx    = 1'b0;
                    w_next_state = IDLE;
                end else begin
                    w_next_cnt = r_hold_cnt - 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_tx    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state      <= IDLE;
            dout         <= '0;
            tx_valid     <= 1'b0;
            r_hold_cnt   <= '0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_rx_valid_q <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            dout         <= w_next_dout;
            tx_valid     <= w_next_tx;
            r_hold_cnt   <= w_next_cnt;
            r_rx_valid_q <= rx_valid;
            if (w_accept && (w_op == OP_WR_ADDR)) begin
                r_wr_addr <= w_payload;
            end
            if (w_accept && (w_op == OP_RD_ADDR)) begin
                r_rd_addr <= w_payload;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_spi_ram_ctrl : vector table, corner sequences and random commands  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_spi_ram_ctrl;
    import spi_pkg::*;

    localparam int TX_HOLD = 8;

    logic       CLK = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [9:0] din;
    logic [7:0] dout;
    logic       tx_valid;

    always #5 CLK = ~CLK;

    spi_ram_ctrl #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8),
        .DATA_W    (8),
        .TX_HOLD   (TX_HOLD)
    ) dut (
        .CLK      (CLK),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: memory array plus a timeline of when tx_valid must be high.
    logic [7:0] m_mem [256];
    bit         m_known [256];
    logic [7:0] m_wa, m_ra, m_dout, fetch_val;
    bit         m_prev_v, m_tx, m_dout_known, fetch_known;
    int         k = 0, t_start = 0, t_end = -1, fetch_at = -1;

    function automatic void model_edge(bit r, bit v, logic [9:0] d);
        bit acc;
        k++;
        if (r) begin
            m_wa = 8'h00; m_ra = 8'h00; m_prev_v = 1'b0;
            m_dout = 8'h00; m_dout_known = 1'b1;
            t_start = 0; t_end = -1; fetch_at = -1;
        end else begin
            acc = v && !m_prev_v;
            m_prev_v = v;
            if (k == fetch_at) begin
                m_dout = fetch_val;
                m_dout_known = fetch_known;
            end
            if (acc) begin
                case (d[9:8])
                    OP_WR_ADDR: m_wa = d[7:0];
                    OP_WR_DATA: begin m_mem[m_wa] = d[7:0]; m_known[m_wa] = 1'b1; end
                    OP_RD_ADDR: m_ra = d[7:0];
                    default: begin
                        fetch_at    = k + 1;
                        fetch_val   = m_mem[m_ra];
                        fetch_known = m_known[m_ra];
                        if (!(t_start <= k - 1 && k - 1 <= t_end)) t_start = k + 1;
                        t_end = k + TX_HOLD;
                    end
                endcase
            end
        end
        m_tx = (t_start <= k) && (k <= t_end);
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [9:0] d);
        @(negedge CLK);
        rst = r; rx_valid = v; din = d;
        @(posedge CLK);
        model_edge(r, v, d);
        #1;
        check_eq("tx_valid", 32'(tx_valid), 32'(m_tx));
        if (m_dout_known) check_eq("dout", 32'(dout), 32'(m_dout));
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] pay, input int hi);
        for (int i = 0; i < hi; i++) step(1'b0, 1'b1, {op, pay});
        step(1'b0, 1'b0, {op, pay});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, din);
    endtask

    task automatic count_hi(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, din);
            if (tx_valid) hi++;
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] pay;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int hi, drops;
        bit seen, prev;
        logic [1:0] op;

        tbl[0]  = '{OP_WR_ADDR, 8'h3C, 8'h00};
        tbl[1]  = '{OP_WR_DATA, 8'hA5, 8'h00};
        tbl[2]  = '{OP_RD_ADDR, 8'h3C, 8'h00};
        tbl[3]  = '{OP_RD_DATA, 8'h00, 8'hA5};
        tbl[4]  = '{OP_WR_ADDR, 8'hFF, 8'h00};
        tbl[5]  = '{OP_WR_DATA, 8'h5A, 8'h00};
        tbl[6]  = '{OP_RD_ADDR, 8'hFF, 8'h00};
        tbl[7]  = '{OP_RD_DATA, 8'h77, 8'h5A};
        tbl[8]  = '{OP_WR_ADDR, 8'h00, 8'h00};
        tbl[9]  = '{OP_WR_DATA, 8'h01, 8'h00};
        tbl[10] = '{OP_RD_ADDR, 8'h00, 8'h00};
        tbl[11] = '{OP_RD_DATA, 8'h00, 8'h01};

        rst = 1'b1; rx_valid = 1'b0; din = '0;
        step(1'b1, 1'b0, 10'h000);
        step(1'b1, 1'b0, 10'h000);
        check_eq("reset_dout", 32'(dout), 32'h0);
        check_eq("reset_tx", 32'(tx_valid), 32'h0);

        // Reset in the middle of SEND, then a read of an unwritten address must still finish.
        cmd(OP_RD_ADDR, 8'hEE, 1);
        cmd(OP_RD_DATA, 8'h00, 1);
        idle(2);
        step(1'b1, 1'b0, din);
        step(1'b1, 1'b0, din);
        check_eq("rst_mid_send_tx", 32'(tx_valid), 32'h0);
        check_eq("rst_mid_send_dout", 32'(dout), 32'h0);
        step(1'b0, 1'b1, {OP_RD_DATA, 8'h00});
        count_hi(12, hi);
        check_eq("post_reset_read_hi", 32'(hi), 32'(TX_HOLD));
        check_eq("post_reset_read_done", 32'(tx_valid), 32'h0);

        for (int i = 0; i < 12; i++) begin
            cmd(tbl[i].op, tbl[i].pay, 1);
            if (tbl[i].op == OP_RD_DATA) begin
                idle(10);
                check_eq("table_read", 32'(dout), 32'(tbl[i].exp));
            end
        end

        // Stretched rx_valid must act once.
        cmd(OP_WR_ADDR, 8'h05, 1);
        cmd(OP_WR_DATA, 8'h11, 3);
        cmd(OP_WR_DATA, 8'h22, 1);
        cmd(OP_RD_ADDR, 8'h05, 2);
        cmd(OP_RD_DATA, 8'h00, 1);
        idle(10);
        check_eq("stretched_write", 32'(dout), 32'h22);

        // Restart four cycles into SEND keeps tx_valid high for 4+1+8 cycles.
        hi = 0; drops = 0; seen = 1'b0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i == 0) || (i == 5), {OP_RD_DATA, 8'h00});
            if (tx_valid) begin
                hi++;
                if (seen && !prev) drops++;
                seen = 1'b1;
            end
            prev = tx_valid;
        end
        check_eq("restart_high_time", 32'(hi), 32'd13);
        check_eq("restart_no_drop", 32'(drops), 32'd0);

        // Write to the address being sent: dout holds until the next fetch.
        cmd(OP_WR_ADDR, 8'h20, 1);
        cmd(OP_WR_DATA, 8'h33, 1);
        cmd(OP_RD_ADDR, 8'h20, 1);
        cmd(OP_RD_DATA, 8'h00, 1);
        cmd(OP_WR_DATA, 8'h44, 1);
        check_eq("concurrent_tx", 32'(tx_valid), 32'h1);
        idle(8);
        check_eq("concurrent_hold", 32'(dout), 32'h33);
        cmd(OP_RD_DATA, 8'h00, 1);
        idle(10);
        check_eq("concurrent_new", 32'(dout), 32'h44);

        for (int i = 0; i < 200; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == OP_WR_DATA) cmd(op, 8'($urandom), int'($urandom_range(1, 3)));
            else cmd(op, 8'($urandom_range(0, 15)), int'($urandom_range(1, 3)));
            idle(int'($urandom_range(0, 4)));
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
